// File: rtl/cdc_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_arbiter
//
// Round-robin arbiter that shares one multi-cycle datapath between two
// requesters. One transaction is outstanding at a time:
//   IDLE -> ISSUE -> WAIT -> RESP -> IDLE
// A transaction whose result does not arrive within TIMEOUT WAIT cycles is
// aborted and answered with data=0, err=1.
//
// Parameters
//   TIMEOUT       max WAIT cycles before abort (legal range 2..255)
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset
//   reqN_valid    requester N presents an operation
//   reqN_a/_b     4-bit operands of requester N
//   reqN_mode     operation select, passed through unmodified
//   reqN_ready    request accepted this cycle when valid && ready
//   dp_in_*       one-cycle issue to the shared datapath
//   dp_out_valid  datapath result strobe (only honoured in WAIT)
//   dp_out        8-bit datapath result
//   resp_*        one-cycle result return, no back-pressure
//   busy          high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module cdc_arbiter #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic       req0_mode,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic       req1_mode,
  output logic       req1_ready,
  output logic       dp_in_valid,
  output logic [3:0] dp_in_a,
  output logic [3:0] dp_in_b,
  output logic       dp_mode,
  input  logic       dp_out_valid,
  input  logic [7:0] dp_out,
  output logic       resp_valid,
  output logic       resp_id,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic       prio1_q;     // 1: requester 1 wins a tie (req0 was granted last)
  logic [3:0] a_q, b_q;
  logic       mode_q;
  logic       id_q;
  logic [7:0] cnt_q;
  logic [7:0] data_q;
  logic       err_q;

  logic grant_id;
  logic accept;
  logic timeout_hit;

  // Arbitration and next-state logic.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    grant_id = 1'b0;
    accept   = 1'b0;
    state_d  = state_q;

    if (req0_valid && req1_valid) grant_id = prio1_q;
    else                          grant_id = req1_valid;

    timeout_hit = (cnt_q == TIMEOUT_CNT);

    unique case (state_q)
      S_IDLE: begin
        accept = (req0_valid || req1_valid) && !rst;
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (dp_out_valid || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prio1_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        a_q     <= grant_id ? req1_a    : req0_a;
        b_q     <= grant_id ? req1_b    : req0_b;
        mode_q  <= grant_id ? req1_mode : req0_mode;
        id_q    <= grant_id;
        prio1_q <= ~grant_id;
      end

      // Counter reads k during the k-th WAIT cycle.
      if (state_q == S_ISSUE)     cnt_q <= 8'd1;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + 8'd1;
      else                        cnt_q <= '0;

      // A result arriving on the timeout cycle wins over the abort.
      if (state_q == S_WAIT) begin
        if (dp_out_valid) begin
          data_q <= dp_out;
          err_q  <= 1'b0;
        end else if (timeout_hit) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end
      end
    end
  end

  // Outputs are forced low while rst is high, including the first reset
  // cycle before the state register has been cleared.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    dp_in_valid = 1'b0;
    dp_in_a     = '0;
    dp_in_b     = '0;
    dp_mode     = 1'b0;
    resp_valid  = 1'b0;
    resp_id     = 1'b0;
    resp_data   = '0;
    resp_err    = 1'b0;
    busy        = 1'b0;

    if (!rst) begin
      busy = (state_q != S_IDLE);
      if (state_q == S_IDLE) begin
        req0_ready = req0_valid && !grant_id;
        req1_ready = req1_valid &&  grant_id;
      end
      if (state_q == S_ISSUE) begin
        dp_in_valid = 1'b1;
        dp_in_a     = a_q;
        dp_in_b     = b_q;
        dp_mode     = mode_q;
      end
      if (state_q == S_RESP) begin
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_data  = data_q;
        resp_err   = err_q;
      end
    end
  end

endmodule

// File: tb/tb_cdc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdc_arbiter
//
// Self-checking bench for cdc_arbiter. Inputs change on the falling edge and
// outputs are compared 1 ns later. The reference model tracks only which
// requester was granted last and derives every expected grant, issue and
// response from the arbitration and timeout rules.
// -----------------------------------------------------------------------------
module tb_cdc_arbiter;

  localparam int TIMEOUT = 31;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_mode, req1_mode;
  logic       req0_ready, req1_ready;
  logic       dp_in_valid;
  logic [3:0] dp_in_a, dp_in_b;
  logic       dp_mode;
  logic       dp_out_valid;
  logic [7:0] dp_out;
  logic       resp_valid, resp_id, resp_err;
  logic [7:0] resp_data;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: requester granted last (1 after reset, so req0
  // wins the first tie) and the operands each requester currently holds.
  int         last_g;
  logic [3:0] op_a [2];
  logic [3:0] op_b [2];
  logic       op_m [2];

  cdc_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_mode    (req0_mode),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_mode    (req1_mode),
    .req1_ready   (req1_ready),
    .dp_in_valid  (dp_in_valid),
    .dp_in_a      (dp_in_a),
    .dp_in_b      (dp_in_b),
    .dp_mode      (dp_mode),
    .dp_out_valid (dp_out_valid),
    .dp_out       (dp_out),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_ops();
    req0_a = op_a[0]; req0_b = op_b[0]; req0_mode = op_m[0];
    req1_a = op_a[1]; req1_b = op_b[1]; req1_mode = op_m[1];
  endtask

  // One full transaction starting at a falling edge with the DUT in IDLE.
  // lat: WAIT cycle on which the datapath answers (0 = never).
  // rst_at: WAIT cycle on which a one-cycle reset is applied (0 = none).
  task automatic do_txn(input bit v0, input bit v1, input int lat,
                        input logic [7:0] data, input int rst_at);
    int         g;
    logic [7:0] exp_data;
    logic       exp_err;

    req0_valid = v0;
    req1_valid = v1;
    drive_ops();
    g = (v0 && v1) ? (last_g == 0 ? 1 : 0) : (v0 ? 0 : 1);
    #1;
    check("idle_ready0", 32'(req0_ready), 32'(g == 0));
    check("idle_ready1", 32'(req1_ready), 32'(g == 1));
    check("idle_busy",   32'(busy), 0);

    tick();  // ISSUE
    if (g == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    last_g = g;
    #1;
    check("issue_valid", 32'(dp_in_valid), 1);
    check("issue_a",     32'(dp_in_a), 32'(op_a[g]));
    check("issue_b",     32'(dp_in_b), 32'(op_b[g]));
    check("issue_mode",  32'(dp_mode), 32'(op_m[g]));
    check("issue_ready", 32'({req0_ready, req1_ready}), 0);
    check("issue_busy",  32'(busy), 1);

    tick();  // first WAIT cycle
    for (int k = 1; k <= TIMEOUT; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_resp", 32'(resp_valid), 0);
        tick();
        rst = 1'b0;
        last_g = 1;
        for (int s = 0; s < 3; s++) begin
          dp_out_valid = 1'b1;
          dp_out = data;
          #1;
          check("post_rst_busy", 32'(busy), 0);
          check("post_rst_resp", 32'({resp_valid, resp_data}), 0);
          tick();
        end
        dp_out_valid = 1'b0;
        return;
      end
      if (k == lat) begin
        dp_out_valid = 1'b1;
        dp_out = data;
      end
      #1;
      check("wait_busy",  32'(busy), 1);
      check("wait_resp",  32'(resp_valid), 0);
      check("wait_dp_in", 32'({dp_in_valid, dp_in_a, dp_in_b, dp_mode}), 0);
      if (k == lat || k == TIMEOUT) break;
      tick();
    end

    tick();  // RESP
    // A result strobe during RESP must be ignored.
    dp_out_valid = $urandom_range(0, 1);
    dp_out = 8'($urandom);
    exp_err  = !(lat >= 1 && lat <= TIMEOUT);
    exp_data = exp_err ? 8'h00 : data;
    #1;
    check("resp_valid", 32'(resp_valid), 1);
    check("resp_id",    32'(resp_id), 32'(g));
    check("resp_data",  32'(resp_data), 32'(exp_data));
    check("resp_err",   32'(resp_err), 32'(exp_err));
    check("resp_busy",  32'(busy), 1);

    tick();  // back to IDLE
    dp_out_valid = 1'b0;
    #1;
    check("done_resp", 32'({resp_valid, resp_id, resp_data, resp_err}), 0);
    check("done_busy", 32'(busy), 0);

    op_a[g] = 4'($urandom);
    op_b[g] = 4'($urandom);
    op_m[g] = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    dp_out_valid = 1'b0;
    dp_out = '0;
    last_g = 1;
    for (int i = 0; i < 2; i++) begin
      op_a[i] = 4'($urandom);
      op_b[i] = 4'($urandom);
      op_m[i] = 1'($urandom);
    end
    drive_ops();

    // Outputs stay low during reset even with both requests valid.
    #1;
    check("rst_outputs0", 32'({req0_ready, req1_ready, dp_in_valid, resp_valid, busy}), 0);
    tick();
    check("rst_outputs1", 32'({req0_ready, req1_ready, dp_in_valid, resp_valid, busy}), 0);
    check("rst_dp_resp",  32'({dp_in_a, dp_in_b, resp_data}), 0);
    tick();
    rst = 1'b0;

    // Contention from reset: req0 first, then req1, then alternating 0,1,0,1.
    do_txn(1, 1, 2, 8'h11, 0);
    do_txn(0, 1, 3, 8'h22, 0);
    for (int i = 0; i < 4; i++) do_txn(1, 1, 1 + i, 8'(8'h30 + i), 0);

    // Single request with fixed operands and a 4-cycle datapath.
    op_a[0] = 4'd3; op_b[0] = 4'd5; op_m[0] = 1'b0;
    do_txn(1, 0, 4, 8'h08, 0);

    // Timeout: datapath never answers.
    do_txn(0, 1, 0, 8'hAA, 0);

    // Result exactly on the timeout cycle wins.
    do_txn(1, 0, TIMEOUT, 8'hE1, 0);

    // Stray result strobes in IDLE produce nothing.
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      dp_out_valid = 1'b1;
      dp_out = 8'h5A;
      #1;
      check("stray_idle", 32'({resp_valid, resp_data, busy, dp_in_valid}), 0);
      tick();
    end
    dp_out_valid = 1'b0;

    // Reset during WAIT drops the transaction; the next one completes.
    do_txn(1, 1, 10, 8'h77, 3);
    do_txn(1, 1, 5, 8'h9C, 0);

    // Randomized traffic.
    for (int t = 0; t < 30; t++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      do_txn(v0, v1, $urandom_range(0, TIMEOUT), 8'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
